stepper_phase_drv: RTL and testbench
====================================

STEPPER_PHASE_DRV -- requirements
Module: stepper_phase_drv

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL provide port xres, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port div, input, 32, step-period division count (clocks between steps minus 1), synchronous to clk.
REQ-004 SHALL provide port en, input, 1, run enable, synchronous to clk.
REQ-005 SHALL provide port dir, input, 1, direction: 1 forward (index up), 0 reverse.
REQ-006 SHALL provide port half, input, 1, mode: 1 half-step, 0 full-step (two-phase-on).
REQ-007 SHALL provide port phase, output, 4, registered coil drive {D,C,B,A}.
REQ-008 SHALL provide port step_tick, output, 1, registered one-clock pulse per step taken.
REQ-009 SHALL provide port pos, output, 16, registered step position counter.

Function
REQ-010 SHALL hold a 32-bit down-counter cnt; in each cycle with en=1: if cnt==0, cnt<=div (value sampled that cycle) and a step occurs; else cnt<=cnt-1.
REQ-011 SHALL give a step period of div+1 clocks; div==0 yields a step every clock; div==32'hFFFFFFFF SHALL not overflow (reload only, no arithmetic on div).
REQ-012 SHALL apply a changed div only at the next reload; the running count is never truncated.
REQ-013 SHALL, with en=0, force cnt<=0, take no steps, hold idx and pos; the first step occurs in the first cycle en is sampled 1.
REQ-014 SHALL keep a 3-bit phase index idx, updated only on a step, dir and half sampled in the step cycle.
REQ-015 SHALL, half=1, set idx<=idx+1 (dir=1) or idx-1 (dir=0), modulo 8.
REQ-016 SHALL, half=0, set idx<=idx±2 if idx odd, idx±1 if idx even (re-aligns to odd two-phase states), modulo 8.
REQ-017 SHALL decode idx: 0->0001, 1->0011, 2->0010, 3->0110, 4->0100, 5->1100, 6->1000, 7->1001.
REQ-018 SHALL register phase<=decode(idx) each cycle en=1, and phase<=0000 each cycle en=0 (coils de-energised).
REQ-019 SHALL assert step_tick for exactly the clock after each step cycle (same edge idx changes); phase reflects the new idx one clock after step_tick rises.
REQ-020 SHALL update pos<=pos+1 (dir=1) or pos-1 (dir=0) on each step, independent of half, wrapping modulo 2^16 (FFFF+1=0000, 0000-1=FFFF).
REQ-021 SHALL treat a dir or half change in the same cycle as a step as taking effect for that step.

Reset
REQ-022 SHALL, while xres=0, immediately force cnt=0, idx=0, phase=0000, step_tick=0, pos=0000, regardless of clk.
REQ-023 SHALL, on xres deassertion mid-operation, resume per REQ-013 as if en had just risen; no partial period is retained.

Structure
REQ-024 SHALL place the 8-entry phase decode table, IDX_W=3, POS_W=16 and DIV_W=32 constants in shared package stepper_pkg.
REQ-025 SHALL implement the period counter (REQ-010..013) as sub-module step_timer (ports clk, xres, en, div, step), phase sequencing and pos in the top.

Verification
REQ-026 SHALL check: reset, en=1, div=3, dir=1, half=1 -> step_tick pulses every 4 clocks, phase 0011,0010,0110,... , pos 1,2,3.
REQ-027 SHALL check: div=0, half=0, dir=1 from idx=0 -> idx 1,3,5,7,1; phase 0011,0110,1100,1001; step_tick high every clock.
REQ-028 SHALL check: dir=0 from reset, half=1 -> idx 7 (phase 1001), pos FFFF; further steps pos FFFE, FFFD.
REQ-029 SHALL check: div changed 9->2 mid-period -> current period completes at 10 clocks, subsequent periods 3 clocks.
REQ-030 SHALL check: en dropped for 5 clocks mid-run -> phase 0000, pos/idx held; en re-raised -> step in first cycle, phase resumes from held idx+1.
REQ-031 SHALL check: xres pulsed low between clk edges during run -> all outputs zero immediately, restart per REQ-023.

Source files
------------

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared constants, phase decode table and index sequencing helper for the stepper driver
//
// Contents:
//   IDX_W, POS_W, DIV_W  widths of phase index, position counter and period divider
//   PHASE_TABLE          idx -> coil drive {D,C,B,A}
//   dir_e                direction encoding of the dir input
//   phase_decode()       table lookup
//   next_idx()           phase index advance for half/full stepping
package stepper_pkg;

    localparam int IDX_W = 3;
    localparam int POS_W = 16;
    localparam int DIV_W = 32;

    // Entry [i] is the coil pattern for idx == i; odd entries energise two coils.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001,  // 7
        4'b1000,  // 6
        4'b1100,  // 5
        4'b0100,  // 4
        4'b0110,  // 3
        4'b0010,  // 2
        4'b0011,  // 1
        4'b0001   // 0
    };

    typedef enum logic {
        DIR_REV = 1'b0,
        DIR_FWD = 1'b1
    } dir_e;

    function automatic logic [3:0] phase_decode(input logic [IDX_W-1:0] idx);
        return PHASE_TABLE[idx];
    endfunction

    // Full-step mode only uses the odd (two-phase-on) states: from an odd index
    // jump by two, from an even index move by one to land back on an odd state.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input dir_e             dir,
                                                  input logic             half);
        logic [IDX_W-1:0] inc;
        inc = (half || !idx[0]) ? IDX_W'(1) : IDX_W'(2);
        return (dir == DIR_FWD) ? idx + inc : idx - inc;
    endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step period down-counter producing one step strobe every div+1 enabled clocks
//
// Ports:
//   clk   system clock
//   xres  asynchronous active-low reset
//   en    run enable; low clears the counter so the next enabled cycle steps at once
//   div   period minus one, sampled only at reload
//   step  combinational strobe, high in each cycle a step is taken
module step_timer
    import stepper_pkg::*;
(
    input  logic             clk,
    input  logic             xres,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign step = en && (cnt_q == '0);

    // div is only ever copied, never incremented, so all-ones cannot overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = div;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stepper_phase_drv.sv
// rtl/stepper_phase_drv.sv - stepper motor phase driver: timed steps, half/full sequencing, position count
//
// Ports:
//   clk        system clock
//   xres       asynchronous active-low reset
//   div        step period minus one (clocks)
//   en         run enable; low de-energises the coils and holds position
//   dir        1 forward (index up), 0 reverse
//   half       1 half-step, 0 full-step two-phase-on
//   phase      registered coil drive {D,C,B,A}
//   step_tick  registered one-clock pulse per step
//   pos        registered step position, wraps modulo 2^16
module stepper_phase_drv
    import stepper_pkg::*;
(
    input  logic             clk,
    input  logic             xres,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    input  logic             dir,
    input  logic             half,
    output logic [3:0]       phase,
    output logic             step_tick,
    output logic [POS_W-1:0] pos
);

    logic             step;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [3:0]       phase_q,     phase_d;
    logic             step_tick_q, step_tick_d;
    logic [POS_W-1:0] pos_q,       pos_d;

    step_timer u_step_timer (
        .clk  (clk),
        .xres (xres),
        .en   (en),
        .div  (div),
        .step (step)
    );

    // phase decodes the registered idx, so it trails the idx update (and
    // step_tick) by one clock.
    always_comb begin
        idx_d       = idx_q;
        pos_d       = pos_q;
        step_tick_d = step;
        phase_d     = en ? phase_decode(idx_q) : 4'b0000;
        if (step) begin
            idx_d = next_idx(idx_q, dir_e'(dir), half);
            pos_d = dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            idx_q       <= '0;
            phase_q     <= 4'b0000;
            step_tick_q <= 1'b0;
            pos_q       <= '0;
        end else begin
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            step_tick_q <= step_tick_d;
            pos_q       <= pos_d;
        end
    end

    assign phase     = phase_q;
    assign step_tick = step_tick_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_stepper_phase_drv.sv
// tb/tb_stepper_phase_drv.sv - directed self-checking bench for stepper_phase_drv
module tb_stepper_phase_drv;

    logic        clk = 1'b0;
    logic        xres;
    logic [31:0] div;
    logic        en;
    logic        dir;
    logic        half;
    logic [3:0]  phase;
    logic        step_tick;
    logic [15:0] pos;

    int checks   = 0;
    int failures = 0;

    stepper_phase_drv dut (
        .clk       (clk),
        .xres      (xres),
        .div       (div),
        .en        (en),
        .dir       (dir),
        .half      (half),
        .phase     (phase),
        .step_tick (step_tick),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs are driven and
    // outputs sampled at that point.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check outputs clear without a clock edge, release.
    task automatic pulse_reset(input string tag);
        #3;
        xres = 1'b0;
        #1;
        chk({tag, "_rst_phase"}, 32'(phase), 32'h0);
        chk({tag, "_rst_tick"},  32'(step_tick), 32'h0);
        chk({tag, "_rst_pos"},   32'(pos), 32'h0);
        #1;
        xres = 1'b1;
    endtask

    initial begin
        xres = 1'b0; div = 32'd3; en = 1'b0; dir = 1'b1; half = 1'b1;
        #1;
        chk("init_phase", 32'(phase), 32'h0);
        chk("init_tick",  32'(step_tick), 32'h0);
        chk("init_pos",   32'(pos), 32'h0);
        edge1();
        edge1();
        chk("rst_hold_pos", 32'(pos), 32'h0);
        xres = 1'b1;
        edge1();
        chk("en0_phase", 32'(phase), 32'h0);
        chk("en0_tick",  32'(step_tick), 32'h0);

        // div=3, forward, half-step: tick every 4 clocks
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            edge1();
            chk($sformatf("t1_tick_e%0d", k), 32'(step_tick), 32'((k % 4) == 1));
            if (k == 1)  chk("t1_pos_e1", 32'(pos), 32'h1);
            if (k == 2)  chk("t1_phase_e2", 32'(phase), 32'b0011);
            if (k == 5)  chk("t1_pos_e5", 32'(pos), 32'h2);
            if (k == 6)  chk("t1_phase_e6", 32'(phase), 32'b0010);
            if (k == 9)  chk("t1_pos_e9", 32'(pos), 32'h3);
            if (k == 10) chk("t1_phase_e10", 32'(phase), 32'b0110);
        end

        // div=0, full-step, forward from idx 0: idx 1,3,5,7,1
        pulse_reset("t2");
        div = 32'd0; half = 1'b0; dir = 1'b1;
        edge1();
        chk("t2_tick_e1", 32'(step_tick), 32'h1);
        chk("t2_phase_e1", 32'(phase), 32'b0001);
        edge1();
        chk("t2_tick_e2", 32'(step_tick), 32'h1);
        chk("t2_phase_e2", 32'(phase), 32'b0011);
        edge1();
        chk("t2_tick_e3", 32'(step_tick), 32'h1);
        chk("t2_phase_e3", 32'(phase), 32'b0110);
        edge1();
        chk("t2_tick_e4", 32'(step_tick), 32'h1);
        chk("t2_phase_e4", 32'(phase), 32'b1100);
        edge1();
        chk("t2_phase_e5", 32'(phase), 32'b1001);
        chk("t2_pos_e5", 32'(pos), 32'h5);
        edge1();
        chk("t2_phase_e6", 32'(phase), 32'b0011);

        // reverse half-step from reset: idx 7, pos wraps to FFFF
        pulse_reset("t3");
        dir = 1'b0; half = 1'b1;
        edge1();
        chk("t3_pos_e1", 32'(pos), 32'hFFFF);
        edge1();
        chk("t3_phase_e2", 32'(phase), 32'b1001);
        chk("t3_pos_e2", 32'(pos), 32'hFFFE);
        edge1();
        chk("t3_phase_e3", 32'(phase), 32'b1000);
        chk("t3_pos_e3", 32'(pos), 32'hFFFD);

        // div 9 -> 2 mid-period: steps at edges 1, 11, 14, 17
        pulse_reset("t4");
        dir = 1'b1; div = 32'd9;
        for (int k = 1; k <= 18; k++) begin
            edge1();
            chk($sformatf("t4_tick_e%0d", k), 32'(step_tick),
                32'(k == 1 || k == 11 || k == 14 || k == 17));
            if (k == 4) div = 32'd2;
        end
        chk("t4_pos", 32'(pos), 32'h4);

        // en dropped for 5 clocks: coils off, position held, immediate resume
        pulse_reset("t5");
        div = 32'd1;
        for (int k = 1; k <= 5; k++) edge1();
        chk("t5_pos_run", 32'(pos), 32'h3);
        en = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            edge1();
            chk($sformatf("t5_off_phase_e%0d", k), 32'(phase), 32'h0);
            chk($sformatf("t5_off_tick_e%0d", k), 32'(step_tick), 32'h0);
        end
        chk("t5_off_pos", 32'(pos), 32'h3);
        en = 1'b1;
        edge1();
        chk("t5_resume_tick", 32'(step_tick), 32'h1);
        chk("t5_resume_pos", 32'(pos), 32'h4);
        chk("t5_resume_phase0", 32'(phase), 32'b0110);
        edge1();
        chk("t5_resume_phase1", 32'(phase), 32'b0100);

        // reset pulsed mid-run, restart with an immediate step
        div = 32'd0;
        edge1();
        edge1();
        pulse_reset("t6");
        edge1();
        chk("t6_tick", 32'(step_tick), 32'h1);
        chk("t6_pos", 32'(pos), 32'h1);
        chk("t6_phase0", 32'(phase), 32'b0001);
        edge1();
        chk("t6_phase1", 32'(phase), 32'b0011);

        // maximum divider: one step, then a long quiet period
        pulse_reset("t7");
        div = 32'hFFFF_FFFF;
        edge1();
        chk("t7_tick_e1", 32'(step_tick), 32'h1);
        for (int k = 2; k <= 6; k++) begin
            edge1();
            chk($sformatf("t7_tick_e%0d", k), 32'(step_tick), 32'h0);
        end
        chk("t7_pos", 32'(pos), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
